// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encodings and the R/W bus bit values.
package i2c_pkg;
    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] ADDR     = 4'd1;
    localparam logic [STATE_W-1:0] ADDR_ACK = 4'd2;
    localparam logic [STATE_W-1:0] RX_BYTE  = 4'd3;
    localparam logic [STATE_W-1:0] RX_ACK   = 4'd4;
    localparam logic [STATE_W-1:0] TX_BYTE  = 4'd5;
    localparam logic [STATE_W-1:0] TX_ACK   = 4'd6;
    localparam logic [STATE_W-1:0] IGNORE   = 4'd7;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;
endpackage

// File: rtl/i2c_target_if.sv
// User-side handshake of the I2C target: received bytes, transmit byte loading and transfer status.
interface i2c_target_if;
    import i2c_pkg::*;

    logic [7:0]         tx_data;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               tx_load;
    logic               addressed;
    logic               rw;
    logic [STATE_W-1:0] state;

    modport slave  (input tx_data, output rx_data, rx_valid, tx_load, addressed, rw, state);
    modport master (output tx_data, input rx_data, rx_valid, tx_load, addressed, rw, state);
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP detection on the system clock.
// Detection stays masked until every synchronizer and edge flop holds a real pin sample.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_q;
    logic [SYNC_STAGES-1:0] sda_q;
    logic [SYNC_STAGES:0]   fill;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
            fill  <= '0;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
            scl_d <= scl_q[SYNC_STAGES-1];
            sda_d <= sda_q[SYNC_STAGES-1];
            fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign scl_s    = scl_q[SYNC_STAGES-1];
    assign sda_s    = sda_q[SYNC_STAGES-1];
    assign valid    = fill[SYNC_STAGES];
    assign scl_rise = valid &  scl_s & ~scl_d;
    assign scl_fall = valid & ~scl_s &  scl_d;
    assign start    = valid & scl_s & scl_d &  sda_d & ~sda_s;
    assign stop     = valid & scl_s & scl_d & ~sda_d &  sda_s;
endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, ACK, byte receive and transmit; SDA is open-drain, SCL is input only.
// Define I2C_TARGET_GENERAL_CALL_EN to also ACK the general-call write address 7'h00.
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting address + R/W
// ADDR_ACK | driving the address ACK slot
// RX_BYTE  | shifting a write byte
// RX_ACK   | driving the data ACK slot
// TX_BYTE  | driving a read byte
// TX_ACK   | sampling the controller ACK/NACK
// IGNORE   | not ours or NACKed, waiting for START/STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl,
    inout  wire         sda,
    i2c_target_if.slave user
);
    logic               sda_s;
    logic               scl_rise;
    logic               scl_fall;
    logic               start;
    logic               stop;
    logic [STATE_W-1:0] state_q;
    logic [2:0]         bit_cnt;
    logic [6:0]         shift;
    logic [7:0]         rx_byte;
    logic               sda_oe;
    logic               ack_phase;
    logic               addr_match;
    logic [7:0]         rx_data_q;
    logic               rx_valid_q;
    logic               tx_load_q;
    logic               addressed_q;
    logic               rw_q;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign rx_byte = {shift, sda_s};

`ifdef I2C_TARGET_GENERAL_CALL_EN
    assign addr_match = (rx_byte[7:1] == ADDR) || (rx_byte[7:1] == 7'h00 && rx_byte[0] == WRITE);
`else
    assign addr_match = (rx_byte[7:1] == ADDR);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 7'd0;
            sda_oe      <= 1'b0;
            ack_phase   <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= WRITE;
        end else begin
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            if (stop) begin
                state_q     <= IDLE;
                sda_oe      <= 1'b0;
                ack_phase   <= 1'b0;
                addressed_q <= 1'b0;
                bit_cnt     <= 3'd0;
            end else if (start) begin
                state_q     <= i2c_pkg::ADDR;
                sda_oe      <= 1'b0;
                ack_phase   <= 1'b0;
                addressed_q <= 1'b0;
                bit_cnt     <= 3'd0;
            end else begin
                case (state_q)
                    i2c_pkg::ADDR: if (scl_rise) begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_match) begin
                                state_q     <= ADDR_ACK;
                                addressed_q <= 1'b1;
                                rw_q        <= sda_s;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    // First falling edge starts the ACK drive, the second ends the slot.
                    ADDR_ACK, RX_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase <= 1'b1;
                            sda_oe    <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            if (state_q == RX_ACK || rw_q != READ) begin
                                state_q <= RX_BYTE;
                                sda_oe  <= 1'b0;
                            end else begin
                                state_q   <= TX_BYTE;
                                tx_load_q <= 1'b1;
                                shift     <= user.tx_data[6:0];
                                sda_oe    <= ~user.tx_data[7];
                            end
                        end
                    end
                    RX_BYTE: if (scl_rise) begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_q  <= rx_byte;
                            rx_valid_q <= 1'b1;
                            state_q    <= RX_ACK;
                        end
                    end
                    TX_BYTE: if (scl_fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            sda_oe  <= 1'b0;
                            state_q <= TX_ACK;
                        end else begin
                            sda_oe <= ~shift[6];
                            shift  <= {shift[5:0], 1'b0};
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) state_q <= IGNORE;
                            else       ack_phase <= 1'b1;
                        end else if (scl_fall && ack_phase) begin
                            ack_phase <= 1'b0;
                            state_q   <= TX_BYTE;
                            tx_load_q <= 1'b1;
                            shift     <= user.tx_data[6:0];
                            sda_oe    <= ~user.tx_data[7];
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign sda            = sda_oe ? 1'b0 : 1'bz;
    assign user.rx_data   = rx_data_q;
    assign user.rx_valid  = rx_valid_q;
    assign user.tx_load   = tx_load_q;
    assign user.addressed = addressed_q;
    assign user.rw        = rw_q;
    assign user.state     = state_q;
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-level controller model, write-transfer vector table and
// hand-written read, repeated-START and mid-transfer reset sequences.
module tb_i2c_target;
    import i2c_pkg::*;

`ifdef I2C_TARGET_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    localparam int Q  = 40;
    localparam int NV = 6;

    typedef struct {
        logic [6:0] addr;
        int         nbytes;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         exp_ack;
        int         exp_rx;
        logic [3:0] exp_state;
    } wvec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic scl;
    logic m_pull;
    wire  sda;

    int n_cmp = 0;
    int n_bad = 0;
    int rx_total = 0;
    int tx_total = 0;
    logic [7:0] rx_log [64];
    wvec_t vecs [NV];

    i2c_target_if user ();

    i2c_target dut (
        .clk     (clk),
        .reset_n (reset_n),
        .scl     (scl),
        .sda     (sda),
        .user    (user)
    );

    assign sda = m_pull ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (user.rx_valid) begin
                if (rx_total < 64) rx_log[rx_total] = user.rx_data;
                rx_total++;
            end
            if (user.tx_load) tx_total++;
        end
    end

    initial begin
        #(500_000);
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input bit b);
        #(Q) m_pull = ~b;
        #(Q) scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic read_bit(output bit b);
        #(Q) m_pull = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) b = sda;
        #(Q) scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input bit ack, input logic [7:0] next_tx);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        user.tx_data = next_tx;
        write_bit(~ack);
    endtask

    task automatic bus_start();
        #(Q) m_pull = 1'b1;
        #(Q) scl = 1'b0;
    endtask

    task automatic bus_rstart();
        #(Q) m_pull = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) m_pull = 1'b1;
        #(Q) scl = 1'b0;
    endtask

    task automatic bus_stop();
        #(Q) m_pull = 1'b1;
        #(Q) scl = 1'b1;
        #(Q) m_pull = 1'b0;
        #(Q);
        wait_clks(6);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] last;
        logic [7:0] pat;
        bit a;
        int base_rx;
        int base_tx;

        vecs[0] = '{7'h42, 2, 8'hA5, 8'h3C, 1'b1, 2, RX_BYTE};
        vecs[1] = '{7'h17, 1, 8'h55, 8'h00, 1'b0, 0, IGNORE};
        vecs[2] = '{7'h00, 1, 8'h5E, 8'h00, GC, GC ? 1 : 0, GC ? RX_BYTE : IGNORE};
        vecs[3] = '{7'h43, 1, 8'h81, 8'h00, 1'b0, 0, IGNORE};
        vecs[4] = '{7'h21, 1, 8'hFF, 8'h00, 1'b0, 0, IGNORE};
        vecs[5] = '{7'h42, 1, 8'h00, 8'h00, 1'b1, 1, RX_BYTE};

        reset_n = 1'b0;
        scl = 1'b1;
        m_pull = 1'b0;
        user.tx_data = 8'h00;
        #(20);
        check("reset_state", 32'(user.state), 32'(IDLE));
        check("reset_rx_data", 32'(user.rx_data), 32'h0);
        check("reset_rx_valid", 32'(user.rx_valid), 32'h0);
        check("reset_tx_load", 32'(user.tx_load), 32'h0);
        check("reset_addressed", 32'(user.addressed), 32'h0);
        check("reset_rw", 32'(user.rw), 32'h0);
        check("reset_sda", 32'(sda), 32'h1);

        // SDA already low when reset releases must not look like a START
        m_pull = 1'b1;
        #(20);
        reset_n = 1'b1;
        wait_clks(10);
        check("low_bus_no_start", 32'(user.state), 32'(IDLE));
        m_pull = 1'b0;
        wait_clks(10);
        check("low_bus_release", 32'(user.state), 32'(IDLE));

        for (int i = 0; i < NV; i++) begin
            base_rx = rx_total;
            bus_start();
            write_byte({vecs[i].addr, WRITE}, a);
            check($sformatf("v%0d_addr_ack", i), 32'(a), 32'(vecs[i].exp_ack));
            for (int b = 0; b < vecs[i].nbytes; b++) begin
                write_byte((b == 0) ? vecs[i].d0 : vecs[i].d1, a);
                check($sformatf("v%0d_data%0d_ack", i, b), 32'(a), 32'(vecs[i].exp_ack));
            end
            wait_clks(6);
            check($sformatf("v%0d_state_mid", i), 32'(user.state), 32'(vecs[i].exp_state));
            check($sformatf("v%0d_addressed_mid", i), 32'(user.addressed), 32'(vecs[i].exp_ack));
            if (vecs[i].exp_ack) check($sformatf("v%0d_rw", i), 32'(user.rw), 32'(WRITE));
            bus_stop();
            check($sformatf("v%0d_addressed_stop", i), 32'(user.addressed), 32'h0);
            check($sformatf("v%0d_state_stop", i), 32'(user.state), 32'(IDLE));
            check($sformatf("v%0d_rx_count", i), 32'(rx_total - base_rx), 32'(vecs[i].exp_rx));
            if (vecs[i].exp_rx > 0) begin
                last = (vecs[i].nbytes == 2) ? vecs[i].d1 : vecs[i].d0;
                check($sformatf("v%0d_rx_first", i), 32'(rx_log[base_rx]), 32'(vecs[i].d0));
                check($sformatf("v%0d_rx_data", i), 32'(user.rx_data), 32'(last));
            end
        end

        // read 0x96 then 0x0F, controller ACKs the first and NACKs the second
        base_tx = tx_total;
        user.tx_data = 8'h96;
        bus_start();
        write_byte({7'h42, READ}, a);
        check("rd_addr_ack", 32'(a), 32'h1);
        check("rd_rw", 32'(user.rw), 32'(READ));
        read_byte(d, 1'b1, 8'h0F);
        check("rd_byte0", 32'(d), 32'h96);
        read_byte(d, 1'b0, 8'h00);
        check("rd_byte1", 32'(d), 32'h0F);
        wait_clks(6);
        check("rd_state_nack", 32'(user.state), 32'(IGNORE));
        check("rd_tx_loads", 32'(tx_total - base_tx), 32'h2);
        #(Q);
        check("rd_sda_released", 32'(sda), 32'h1);
        bus_stop();
        check("rd_state_stop", 32'(user.state), 32'(IDLE));

        // general-call read is never accepted
        bus_start();
        write_byte({7'h00, READ}, a);
        check("gc_read_ack", 32'(a), 32'h0);
        check("gc_read_state", 32'(user.state), 32'(IGNORE));
        bus_stop();

        // write 0x11, repeated START, read back without an intervening STOP
        base_tx = tx_total;
        user.tx_data = 8'h5A;
        bus_start();
        write_byte({7'h42, WRITE}, a);
        check("rs_waddr_ack", 32'(a), 32'h1);
        write_byte(8'h11, a);
        check("rs_wdata_ack", 32'(a), 32'h1);
        check("rs_rx_data", 32'(user.rx_data), 32'h11);
        bus_rstart();
        write_byte({7'h42, READ}, a);
        check("rs_raddr_ack", 32'(a), 32'h1);
        wait_clks(6);
        check("rs_rw", 32'(user.rw), 32'(READ));
        check("rs_tx_load", 32'(tx_total - base_tx), 32'h1);
        check("rs_state", 32'(user.state), 32'(TX_BYTE));
        read_byte(d, 1'b0, 8'h00);
        check("rs_rd_byte", 32'(d), 32'h5A);
        bus_stop();

        // reset while the target pulls SDA low in a data ACK slot
        pat = 8'hC3;
        bus_start();
        write_byte({7'h42, WRITE}, a);
        check("rst_addr_ack", 32'(a), 32'h1);
        for (int i = 7; i >= 0; i--) write_bit(pat[i]);
        #(Q) m_pull = 1'b0;
        #(Q) scl = 1'b1;
        #(Q);
        check("rst_sda_driven", 32'(sda), 32'h0);
        check("rst_pre_addressed", 32'(user.addressed), 32'h1);
        check("rst_pre_rx_data", 32'(user.rx_data), 32'hC3);
        #(2) reset_n = 1'b0;
        #(1);
        check("rst_sda_z", 32'(sda), 32'h1);
        check("rst_state", 32'(user.state), 32'(IDLE));
        check("rst_rx_data", 32'(user.rx_data), 32'h0);
        check("rst_rx_valid", 32'(user.rx_valid), 32'h0);
        check("rst_tx_load", 32'(user.tx_load), 32'h0);
        check("rst_addressed", 32'(user.addressed), 32'h0);
        check("rst_rw", 32'(user.rw), 32'h0);
        #(7);
        #(Q) reset_n = 1'b1;
        wait_clks(8);
        bus_start();
        write_byte({7'h42, WRITE}, a);
        check("post_rst_addr_ack", 32'(a), 32'h1);
        write_byte(8'h77, a);
        check("post_rst_data_ack", 32'(a), 32'h1);
        bus_stop();
        check("post_rst_rx_data", 32'(user.rx_data), 32'h77);
        check("post_rst_state", 32'(user.state), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
